// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller with multdiv start/wait FSM for the 5-stage core.
// Optional performance counters enabled by defining STALL_PERF_COUNTERS_EN.
module pipeline_stall_controller #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_use_stall,
  input  logic        branch_taken,
  input  logic [4:0]  dx_opcode,
  input  logic [4:0]  dx_alu_op,
  input  logic        md_result_rdy,
  output logic        pc_we,
  output logic        fd_we,
  output logic        dx_we,
  output logic        xm_we,
  output logic        mw_we,
  output logic        fd_flush,
  output logic        dx_insert_nop,
  output logic        xm_insert_nop,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic        md_busy,
  output logic        md_err_timeout,
  output logic [31:0] perf_md_stalls,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [4:0] OPC_ALU = 5'd0;
  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic          err_r;
  logic          md_op_s;
  logic          timeout_s;
  logic          freeze_s;
  logic          lu_cyc_s;
  logic          flush_cyc_s;

  assign md_op_s = (dx_opcode == OPC_ALU) && ((dx_alu_op == ALU_MUL) || (dx_alu_op == ALU_DIV));
  assign md_err_timeout = err_r;

  // Next-state and all pipeline controls; reset forces every output low.
  always_comb begin
    state_next_s  = state_r;
    pc_we         = 1'b0;
    fd_we         = 1'b0;
    dx_we         = 1'b0;
    xm_we         = 1'b0;
    mw_we         = 1'b0;
    fd_flush      = 1'b0;
    dx_insert_nop = 1'b0;
    xm_insert_nop = 1'b0;
    md_ctrl_mult  = 1'b0;
    md_ctrl_div   = 1'b0;
    md_busy       = 1'b0;
    timeout_s     = 1'b0;
    freeze_s      = 1'b0;
    lu_cyc_s      = 1'b0;
    flush_cyc_s   = 1'b0;
    if (reset) begin
      state_next_s = IDLE;
    end else begin
      md_busy = (state_r != IDLE);
      case (state_r)
        IDLE: begin
          if (md_op_s) begin
            freeze_s     = 1'b1;
            md_ctrl_mult = (dx_alu_op == ALU_MUL);
            md_ctrl_div  = (dx_alu_op == ALU_DIV);
            state_next_s = MD_WAIT;
          end else if (branch_taken) begin
            {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b11111;
            fd_flush      = 1'b1;
            dx_insert_nop = 1'b1;
            flush_cyc_s   = 1'b1;
          end else if (load_use_stall) begin
            {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b00111;
            dx_insert_nop = 1'b1;
            lu_cyc_s      = 1'b1;
          end else begin
            {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b11111;
          end
        end
        MD_WAIT: begin
          freeze_s = 1'b1;
          if (md_result_rdy) begin
            state_next_s = MD_DONE;
          end else if (cnt_r == CNT_LAST) begin
            timeout_s    = 1'b1;
            state_next_s = MD_DONE;
          end else begin
            state_next_s = MD_WAIT;
          end
        end
        MD_DONE: begin
          {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b11111;
          state_next_s = IDLE;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
      // Freeze: hold PC/FD/DX with the mul/div in DX, bubble into XM.
      if (freeze_s) begin
        {pc_we, fd_we, dx_we, xm_we, mw_we} = 5'b00011;
        xm_insert_nop = 1'b1;
      end else begin
        xm_insert_nop = 1'b0;
      end
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= (state_r == MD_WAIT) ? (cnt_r + CNT_ONE) : '0;
      err_r   <= err_r | timeout_s;
    end
  end

`ifdef STALL_PERF_COUNTERS_EN
  logic [31:0] perf_md_r;
  logic [31:0] perf_lu_r;
  logic [31:0] perf_fl_r;

  // Free-running wrap-around stall/flush event counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_md_r <= 32'd0;
      perf_lu_r <= 32'd0;
      perf_fl_r <= 32'd0;
    end else begin
      perf_md_r <= perf_md_r + {31'd0, freeze_s};
      perf_lu_r <= perf_lu_r + {31'd0, lu_cyc_s};
      perf_fl_r <= perf_fl_r + {31'd0, flush_cyc_s};
    end
  end

  assign perf_md_stalls = perf_md_r;
  assign perf_lu_stalls = perf_lu_r;
  assign perf_flushes   = perf_fl_r;
`else
  assign perf_md_stalls = 32'd0;
  assign perf_lu_stalls = 32'd0;
  assign perf_flushes   = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: vector table plus multi-cycle mul/div,
// timeout, reset and perf-counter sequences (perf checks follow STALL_PERF_COUNTERS_EN).
module tb_pipeline_stall_controller;

  // Output pattern bit order: {pc,fd,dx,xm,mw, fd_flush,dx_nop,xm_nop, mult,div, busy}
  localparam logic [10:0] P_ZERO  = 11'b00000_000_00_0;
  localparam logic [10:0] P_RUN   = 11'b11111_000_00_0;
  localparam logic [10:0] P_LU    = 11'b00111_010_00_0;
  localparam logic [10:0] P_BR    = 11'b11111_110_00_0;
  localparam logic [10:0] P_MUL   = 11'b00011_001_10_0;
  localparam logic [10:0] P_DIV   = 11'b00011_001_01_0;
  localparam logic [10:0] P_WAIT  = 11'b00011_001_00_1;
  localparam logic [10:0] P_DONE  = 11'b11111_000_00_1;

  logic clock = 1'b0;
  logic reset, load_use_stall, branch_taken, md_result_rdy;
  logic [4:0] dx_opcode, dx_alu_op;

  logic pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_insert_nop, xm_insert_nop;
  logic md_ctrl_mult, md_ctrl_div, md_busy, md_err_timeout;
  logic [31:0] perf_md_stalls, perf_lu_stalls, perf_flushes;

  logic t_pc_we, t_fd_we, t_dx_we, t_xm_we, t_mw_we, t_fd_flush, t_dx_insert_nop, t_xm_insert_nop;
  logic t_md_ctrl_mult, t_md_ctrl_div, t_md_busy, t_md_err_timeout;
  logic [31:0] t_perf_md_stalls, t_perf_lu_stalls, t_perf_flushes;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_stall_controller dut (
    .clock(clock), .reset(reset), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .dx_opcode(dx_opcode), .dx_alu_op(dx_alu_op), .md_result_rdy(md_result_rdy),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
    .fd_flush(fd_flush), .dx_insert_nop(dx_insert_nop), .xm_insert_nop(xm_insert_nop),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_busy(md_busy),
    .md_err_timeout(md_err_timeout), .perf_md_stalls(perf_md_stalls),
    .perf_lu_stalls(perf_lu_stalls), .perf_flushes(perf_flushes)
  );

  pipeline_stall_controller #(.MD_TIMEOUT(8)) dut_to (
    .clock(clock), .reset(reset), .load_use_stall(load_use_stall), .branch_taken(branch_taken),
    .dx_opcode(dx_opcode), .dx_alu_op(dx_alu_op), .md_result_rdy(md_result_rdy),
    .pc_we(t_pc_we), .fd_we(t_fd_we), .dx_we(t_dx_we), .xm_we(t_xm_we), .mw_we(t_mw_we),
    .fd_flush(t_fd_flush), .dx_insert_nop(t_dx_insert_nop), .xm_insert_nop(t_xm_insert_nop),
    .md_ctrl_mult(t_md_ctrl_mult), .md_ctrl_div(t_md_ctrl_div), .md_busy(t_md_busy),
    .md_err_timeout(t_md_err_timeout), .perf_md_stalls(t_perf_md_stalls),
    .perf_lu_stalls(t_perf_lu_stalls), .perf_flushes(t_perf_flushes)
  );

  logic [10:0] out_s, out_to_s;
  assign out_s    = {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_insert_nop, xm_insert_nop,
                     md_ctrl_mult, md_ctrl_div, md_busy};
  assign out_to_s = {t_pc_we, t_fd_we, t_dx_we, t_xm_we, t_mw_we, t_fd_flush, t_dx_insert_nop,
                     t_xm_insert_nop, t_md_ctrl_mult, t_md_ctrl_div, t_md_busy};

  typedef struct {
    logic        lu;
    logic        br;
    logic [4:0]  opc;
    logic [4:0]  alu;
    logic        rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d", name, act, act, exp);
    end
  endtask

  task automatic check11(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock cycle: check at the falling edge, then advance past the rising edge.
  task automatic cyc(input string name, input logic [10:0] exp, input bit use_to,
                     input bit chk_err, input logic exp_err);
    @(negedge clock);
    if (use_to) begin
      check11(name, out_to_s, exp);
      if (chk_err) check32({name, "_err"}, {31'd0, t_md_err_timeout}, {31'd0, exp_err});
    end else begin
      check11(name, out_s, exp);
      if (chk_err) check32({name, "_err"}, {31'd0, md_err_timeout}, {31'd0, exp_err});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic lu, input logic br, input logic [4:0] opc,
                        input logic [4:0] alu, input logic rdy);
    load_use_stall = lu;
    branch_taken   = br;
    dx_opcode      = opc;
    dx_alu_op      = alu;
    md_result_rdy  = rdy;
  endtask

  task automatic check_perf(input string name, input logic [31:0] md, input logic [31:0] lu,
                            input logic [31:0] fl);
`ifdef STALL_PERF_COUNTERS_EN
    check32({name, "_md"}, perf_md_stalls, md);
    check32({name, "_lu"}, perf_lu_stalls, lu);
    check32({name, "_fl"}, perf_flushes, fl);
`else
    check32({name, "_md"}, perf_md_stalls, 32'd0);
    check32({name, "_lu"}, perf_lu_stalls, 32'd0);
    check32({name, "_fl"}, perf_flushes, 32'd0);
`endif
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, P_LU};
    vecs[1] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, P_RUN};
    vecs[2] = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, P_BR};
    vecs[3] = '{1'b0, 1'b1, 5'd3, 5'd1, 1'b0, P_BR};
    vecs[4] = '{1'b0, 1'b0, 5'd1, 5'd6, 1'b0, P_RUN};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 5'd5, 1'b0, P_RUN};
    vecs[6] = '{1'b1, 1'b0, 5'd0, 5'd8, 1'b0, P_LU};
    vecs[7] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b1, P_RUN};
    vecs[8] = '{1'b0, 1'b0, 5'd2, 5'd7, 1'b0, P_RUN};

    reset = 1'b1;
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    set_in(1'b1, 1'b1, 5'd0, 5'd6, 1'b1);
    cyc("reset_outs", P_ZERO, 1'b0, 1'b0, 1'b0);
    cyc("reset_outs_to", P_ZERO, 1'b1, 1'b1, 1'b0);
    check_perf("reset_perf", 32'd0, 32'd0, 32'd0);
    reset = 1'b0;

    // Single-cycle IDLE behaviour (includes load-use then run, branch over load-use).
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].lu, vecs[i].br, vecs[i].opc, vecs[i].alu, vecs[i].rdy);
      cyc($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 1'b1, 1'b0);
    end

    // mul with result ready at cycle 17.
    set_in(1'b0, 1'b0, 5'd0, 5'd6, 1'b0);
    cyc("mul_c0", P_MUL, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 16; c++) cyc($sformatf("mul_c%0d", c), P_WAIT, 1'b0, 1'b0, 1'b0);
    md_result_rdy = 1'b1;
    cyc("mul_c17", P_WAIT, 1'b0, 1'b0, 1'b0);
    md_result_rdy = 1'b0;
    cyc("mul_c18", P_DONE, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc("mul_c19", P_RUN, 1'b0, 1'b0, 1'b0);

    // Timeout with MD_TIMEOUT=8 on the second instance.
    reset = 1'b1;
    cyc("to_reset", P_ZERO, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    set_in(1'b0, 1'b0, 5'd0, 5'd7, 1'b0);
    cyc("to_c0", P_DIV, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) cyc($sformatf("to_c%0d", c), P_WAIT, 1'b1, 1'b1, 1'b0);
    cyc("to_c9", P_DONE, 1'b1, 1'b1, 1'b1);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc("to_c10", P_RUN, 1'b1, 1'b1, 1'b1);
    md_result_rdy = 1'b1;
    cyc("to_c11", P_RUN, 1'b1, 1'b1, 1'b1);
    md_result_rdy = 1'b0;
    reset = 1'b1;
    cyc("to_reset2", P_ZERO, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    cyc("to_after_reset", P_RUN, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of MD_WAIT; late result-ready ignored.
    set_in(1'b0, 1'b0, 5'd0, 5'd6, 1'b0);
    cyc("rst_c0", P_MUL, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) cyc($sformatf("rst_c%0d", c), P_WAIT, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    reset = 1'b1;
    cyc("rst_mid", P_ZERO, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    md_result_rdy = 1'b1;
    cyc("rst_late_rdy", P_RUN, 1'b0, 1'b1, 1'b0);
    md_result_rdy = 1'b0;
    cyc("rst_after", P_RUN, 1'b0, 1'b0, 1'b0);

    // mul then div back-to-back, then load-use and flush events for the perf counters.
    reset = 1'b1;
    cyc("b2b_reset", P_ZERO, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check_perf("b2b_start", 32'd0, 32'd0, 32'd0);
    set_in(1'b0, 1'b0, 5'd0, 5'd6, 1'b0);
    cyc("b2b_mul0", P_MUL, 1'b0, 1'b0, 1'b0);
    cyc("b2b_mul1", P_WAIT, 1'b0, 1'b0, 1'b0);
    cyc("b2b_mul2", P_WAIT, 1'b0, 1'b0, 1'b0);
    md_result_rdy = 1'b1;
    cyc("b2b_mul3", P_WAIT, 1'b0, 1'b0, 1'b0);
    md_result_rdy = 1'b0;
    cyc("b2b_mul_done", P_DONE, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 5'd0, 5'd7, 1'b0);
    cyc("b2b_div0", P_DIV, 1'b0, 1'b0, 1'b0);
    cyc("b2b_div1", P_WAIT, 1'b0, 1'b0, 1'b0);
    md_result_rdy = 1'b1;
    cyc("b2b_div2", P_WAIT, 1'b0, 1'b0, 1'b0);
    md_result_rdy = 1'b0;
    cyc("b2b_div_done", P_DONE, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc("b2b_lu", P_LU, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 5'd0, 5'd0, 1'b0);
    cyc("b2b_br", P_BR, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 5'd0, 5'd0, 1'b0);
    cyc("b2b_brlu", P_BR, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
    cyc("b2b_run", P_RUN, 1'b0, 1'b0, 1'b0);
    check_perf("b2b_perf", 32'd7, 32'd1, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
